// File: rtl/sr_latch_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_latch_driver_pkg
// Purpose  : Shared state encodings and counter-width helpers for the
//            sr_latch_driver command-side block.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sr_latch_driver_pkg;

  localparam int c_stateW = 3;

  // State encodings. RETRY is the single quiet cycle between a failed
  // readback and the next pulse, so every attempt has the same shape as a
  // freshly accepted command.
  localparam logic [c_stateW-1:0] IDLE  = 3'd0;
  localparam logic [c_stateW-1:0] PULSE = 3'd1;
  localparam logic [c_stateW-1:0] GAP   = 3'd2;
  localparam logic [c_stateW-1:0] CHECK = 3'd3;
  localparam logic [c_stateW-1:0] DONE  = 3'd4;
  localparam logic [c_stateW-1:0] RETRY = 3'd5;

  // Width of a counter that must hold values up to maxVal, plus one bit of
  // headroom so no legal parameter choice can wrap.
  function automatic int cntWidth(input int maxVal);
    return $clog2(maxVal) + 1;
  endfunction

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sr_latch_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : sr_latch_driver_if
// Purpose  : Bundles the request handshake, the S/R latch drive, the Q/Qc
//            readback and the status pulses of sr_latch_driver.
// Ports    : req_valid/req_ready/req_set - request handshake
//            S/R                         - latch drive
//            q_fb/qc_fb                  - latch readback
//            done/err/busy               - status
//   modport slave  : the driver itself
//   modport master : the environment (control logic plus the latch)
// Revision : 1.0 - initial release
// ============================================================================
interface sr_latch_driver_if;
  logic req_valid;
  logic req_ready;
  logic req_set;
  logic S;
  logic R;
  logic q_fb;
  logic qc_fb;
  logic done;
  logic err;
  logic busy;

  modport slave (
    input  req_valid, req_set, q_fb, qc_fb,
    output req_ready, S, R, done, err, busy
  );

  modport master (
    output req_valid, req_set, q_fb, qc_fb,
    input  req_ready, S, R, done, err, busy
  );
endinterface
`default_nettype wire

// File: rtl/sr_drv_timer.sv
`default_nettype none
// ============================================================================
// Module   : sr_drv_timer
// Purpose  : Loadable down-counter with a zero flag. Loaded with LEN-1 on
//            entry to a timed state; o_zero marks the last cycle of it.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            i_load       - load i_loadVal this edge (takes priority)
//            i_loadVal    - value to load
//            o_zero       - count is zero
// Revision : 1.0 - initial release
// ============================================================================
module sr_drv_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadVal,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sr_latch_driver.sv
`default_nettype none
// ============================================================================
// Module   : sr_latch_driver
// Purpose  : Command-side driver for a NOR SR latch. Accepts set/reset
//            requests, drives a registered S or R pulse followed by a quiet
//            0,0 gap, reads Q/Qc back, retries on mismatch and reports
//            done or err. S and R are never high together.
// Ports    : clk  - clock
//            rst  - synchronous active-high reset
//            bus  - sr_latch_driver_if.slave (handshake, S/R, readback,
//                   done/err/busy)
// Params   : PULSE_LEN (>=1), GAP_LEN (>=1), MAX_RETRY (>=0)
// Macro    : SR_LATCH_DRIVER_SKIP_REDUNDANT_EN - when defined, a request that
//            already matches the latch state completes without a pulse.
// Revision : 1.0 - initial release
// ============================================================================
module sr_latch_driver
  import sr_latch_driver_pkg::*;
#(
  parameter int PULSE_LEN = 2,
  parameter int GAP_LEN   = 2,
  parameter int MAX_RETRY = 1
) (
  input  logic              clk,
  input  logic              rst,
  sr_latch_driver_if.slave  bus
);

  localparam int c_timerW = cntWidth(maxOf(PULSE_LEN, GAP_LEN));
  localparam int c_retryW = cntWidth(MAX_RETRY + 1);

  localparam logic [c_timerW-1:0] c_pulseLoad = c_timerW'(PULSE_LEN - 1);
  localparam logic [c_timerW-1:0] c_gapLoad   = c_timerW'(GAP_LEN - 1);
  localparam logic [c_retryW-1:0] c_retryMax  = c_retryW'(MAX_RETRY);

  logic [c_stateW-1:0] r_state, w_stateNext;
  logic                r_cmd, w_cmdNext;
  logic [c_retryW-1:0] r_retryCnt, w_retryNext;
  logic                r_s, r_r, r_done, r_err;
  logic                w_sNext, w_rNext, w_doneNext, w_errNext;
  logic                w_timerLoad;
  logic [c_timerW-1:0] w_timerLoadVal;
  logic                w_timerZero;
  logic                w_match;

  sr_drv_timer #(
    .WIDTH (c_timerW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_timerLoad),
    .i_loadVal (w_timerLoadVal),
    .o_zero    (w_timerZero)
  );

  // Q==Qc is an invalid latch state and fails this test either way.
  assign w_match = (bus.q_fb == r_cmd) && (bus.qc_fb == ~r_cmd);

`ifdef SR_LATCH_DRIVER_SKIP_REDUNDANT_EN
  logic w_redundant;
  assign w_redundant = (bus.q_fb == bus.req_set) && (bus.qc_fb == ~bus.req_set);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cmd      <= 1'b0;
      r_retryCnt <= '0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_cmd      <= w_cmdNext;
      r_retryCnt <= w_retryNext;
      r_s        <= w_sNext;
      r_r        <= w_rNext;
      r_done     <= w_doneNext;
      r_err      <= w_errNext;
    end
  end

  // S/R/done/err are computed for the state being entered and registered,
  // so the pulse is visible in the first cycle of PULSE.
  always_comb begin
    w_stateNext    = r_state;
    w_cmdNext      = r_cmd;
    w_retryNext    = r_retryCnt;
    w_sNext        = 1'b0;
    w_rNext        = 1'b0;
    w_doneNext     = 1'b0;
    w_errNext      = 1'b0;
    w_timerLoad    = 1'b0;
    w_timerLoadVal = c_pulseLoad;

    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_cmdNext   = bus.req_set;
          w_retryNext = '0;
`ifdef SR_LATCH_DRIVER_SKIP_REDUNDANT_EN
          if (w_redundant) begin
            w_stateNext = DONE;
            w_doneNext  = 1'b1;
          end else begin
            w_stateNext = PULSE;
            w_timerLoad = 1'b1;
            w_sNext     = bus.req_set;
            w_rNext     = ~bus.req_set;
          end
`else
          w_stateNext = PULSE;
          w_timerLoad = 1'b1;
          w_sNext     = bus.req_set;
          w_rNext     = ~bus.req_set;
`endif
        end
      end

      PULSE: begin
        if (w_timerZero) begin
          w_stateNext    = GAP;
          w_timerLoad    = 1'b1;
          w_timerLoadVal = c_gapLoad;
        end else begin
          w_sNext = r_cmd;
          w_rNext = ~r_cmd;
        end
      end

      GAP: begin
        if (w_timerZero) begin
          w_stateNext = CHECK;
        end
      end

      CHECK: begin
        if (w_match) begin
          w_stateNext = IDLE;
          w_doneNext  = 1'b1;
        end else if (r_retryCnt == c_retryMax) begin
          w_stateNext = IDLE;
          w_errNext   = 1'b1;
        end else begin
          w_retryNext = r_retryCnt + 1'b1;
          w_stateNext = RETRY;
        end
      end

      RETRY: begin
        w_stateNext = PULSE;
        w_timerLoad = 1'b1;
        w_sNext     = r_cmd;
        w_rNext     = ~r_cmd;
      end

      DONE: begin
        w_stateNext = IDLE;
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign bus.S         = r_s;
  assign bus.R         = r_r;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.busy      = (r_state != IDLE);
  assign bus.req_ready = (r_state == IDLE);

  // The forbidden latch input combination must never reach the pins.
  always_ff @(posedge clk) begin
    assert (!(r_s && r_r));
  end

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_latch_driver
// Purpose  : Directed self-checking bench for sr_latch_driver with a clocked
//            latch model that can be frozen to emulate a stuck latch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst;
  logic stuck = 1'b0;
  logic latchQ = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sr_latch_driver_if bus ();

  sr_latch_driver #(
    .PULSE_LEN (2),
    .GAP_LEN   (2),
    .MAX_RETRY (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Latch model: S sets, R resets; frozen while stuck.
  always @(posedge clk) begin
    if (!stuck) begin
      if (bus.S)      latchQ <= 1'b1;
      else if (bus.R) latchQ <= 1'b0;
    end
  end
  assign bus.q_fb  = latchQ;
  assign bus.qc_fb = ~latchQ;

  // Every-cycle invariants.
  always @(negedge clk) begin
    checks++;
    if ((bus.S & bus.R) !== 1'b0) begin
      errors++;
      $display("FAIL s_r_exclusive at %0t: S=%b R=%b, required S&R=0", $time, bus.S, bus.R);
    end
    checks++;
    if ((bus.done & bus.err) !== 1'b0) begin
      errors++;
      $display("FAIL done_err_exclusive at %0t: done=%b err=%b", $time, bus.done, bus.err);
    end
  end

  // Issue one request and record outputs for cycles 1..n (bit k-1 = cycle k).
  task automatic capture(input logic setVal, input int n,
                         output logic [15:0] sV, output logic [15:0] rV,
                         output logic [15:0] dV, output logic [15:0] eV,
                         output logic [15:0] rdyV);
    sV = '0; rV = '0; dV = '0; eV = '0; rdyV = '0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_set   = setVal;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sV[k]   = bus.S;
      rV[k]   = bus.R;
      dV[k]   = bus.done;
      eV[k]   = bus.err;
      rdyV[k] = bus.req_ready;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.S, bus.R, bus.done, bus.err, bus.busy} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs: S,R,done,err,busy=%b required 00000",
               {bus.S, bus.R, bus.done, bus.err, bus.busy});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b required 1", bus.req_ready);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_set;
    logic [15:0] sV, rV, dV, eV, rdyV;
    capture(1'b1, 6, sV, rV, dV, eV, rdyV);
    checks++;
    if (sV[5:0] !== 6'b000011) begin errors++; $display("FAIL set_S: %b required 000011", sV[5:0]); end
    checks++;
    if (rV[5:0] !== 6'b000000) begin errors++; $display("FAIL set_R: %b required 000000", rV[5:0]); end
    checks++;
    if (dV[5:0] !== 6'b100000) begin errors++; $display("FAIL set_done: %b required 100000", dV[5:0]); end
    checks++;
    if (eV[5:0] !== 6'b000000) begin errors++; $display("FAIL set_err: %b required 000000", eV[5:0]); end
    checks++;
    if (rdyV[5:0] !== 6'b100000) begin errors++; $display("FAIL set_ready: %b required 100000", rdyV[5:0]); end
    checks++;
    if ({bus.q_fb, bus.qc_fb} !== 2'b10) begin
      errors++; $display("FAIL set_latch: Q,Qc=%b required 10", {bus.q_fb, bus.qc_fb});
    end
  endtask

  task automatic test_redundant;
    logic [15:0] sV, rV, dV, eV, rdyV;
    logic [5:0]  sExp, dExp, rdyExp;
`ifdef SR_LATCH_DRIVER_SKIP_REDUNDANT_EN
    sExp = 6'b000000; dExp = 6'b000001; rdyExp = 6'b111110;
`else
    sExp = 6'b000011; dExp = 6'b100000; rdyExp = 6'b100000;
`endif
    capture(1'b1, 6, sV, rV, dV, eV, rdyV);
    checks++;
    if (sV[5:0] !== sExp) begin errors++; $display("FAIL redundant_S: %b required %b", sV[5:0], sExp); end
    checks++;
    if (dV[5:0] !== dExp) begin errors++; $display("FAIL redundant_done: %b required %b", dV[5:0], dExp); end
    checks++;
    if (rdyV[5:0] !== rdyExp) begin errors++; $display("FAIL redundant_ready: %b required %b", rdyV[5:0], rdyExp); end
    checks++;
    if (rV[5:0] !== 6'b000000) begin errors++; $display("FAIL redundant_R: %b required 000000", rV[5:0]); end
  endtask

  task automatic test_reset_cmd;
    logic [15:0] sV, rV, dV, eV, rdyV;
    capture(1'b0, 6, sV, rV, dV, eV, rdyV);
    checks++;
    if (rV[5:0] !== 6'b000011) begin errors++; $display("FAIL rstcmd_R: %b required 000011", rV[5:0]); end
    checks++;
    if (sV[5:0] !== 6'b000000) begin errors++; $display("FAIL rstcmd_S: %b required 000000", sV[5:0]); end
    checks++;
    if (dV[5:0] !== 6'b100000) begin errors++; $display("FAIL rstcmd_done: %b required 100000", dV[5:0]); end
    checks++;
    if ({bus.q_fb, bus.qc_fb} !== 2'b01) begin
      errors++; $display("FAIL rstcmd_latch: Q,Qc=%b required 01", {bus.q_fb, bus.qc_fb});
    end
  endtask

  task automatic test_retry_err;
    logic [15:0] sV, rV, dV, eV, rdyV;
    stuck = 1'b1;
    capture(1'b1, 12, sV, rV, dV, eV, rdyV);
    stuck = 1'b0;
    checks++;
    if (sV[11:0] !== 12'h0C3) begin errors++; $display("FAIL retry_S: %b required 000011000011", sV[11:0]); end
    checks++;
    if (rV[11:0] !== 12'h000) begin errors++; $display("FAIL retry_R: %b required 0", rV[11:0]); end
    checks++;
    if (eV[11:0] !== 12'h800) begin errors++; $display("FAIL retry_err: %b required 100000000000", eV[11:0]); end
    checks++;
    if (dV[11:0] !== 12'h000) begin errors++; $display("FAIL retry_done: %b required 0", dV[11:0]); end
    checks++;
    if (rdyV[11:0] !== 12'h800) begin errors++; $display("FAIL retry_ready: %b required 100000000000", rdyV[11:0]); end
  endtask

  task automatic test_back_to_back;
    logic [11:0] sV, rV, dV, eV, rdyV, bV;
    sV = '0; rV = '0; dV = '0; eV = '0; rdyV = '0; bV = '0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_set   = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) bus.req_set = 1'b0;  // must not affect the command in flight
      sV[k] = bus.S; rV[k] = bus.R; dV[k] = bus.done; eV[k] = bus.err;
      rdyV[k] = bus.req_ready; bV[k] = bus.busy;
      if (k == 11) bus.req_valid = 1'b0;
    end
    checks++;
    if (sV !== 12'h003) begin errors++; $display("FAIL b2b_S: %b required 000000000011", sV); end
    checks++;
    if (rV !== 12'h0C0) begin errors++; $display("FAIL b2b_R: %b required 000011000000", rV); end
    checks++;
    if (dV !== 12'h820) begin errors++; $display("FAIL b2b_done: %b required 100000100000", dV); end
    checks++;
    if (rdyV !== 12'h820) begin errors++; $display("FAIL b2b_ready: %b required 100000100000", rdyV); end
    checks++;
    if (bV !== 12'h7DF) begin errors++; $display("FAIL b2b_busy: %b required 011111011111", bV); end
    checks++;
    if (eV !== 12'h000) begin errors++; $display("FAIL b2b_err: %b required 0", eV); end
  endtask

  task automatic test_reset_mid;
    logic anyDoneErr;
    logic allReady;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_set   = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.S !== 1'b1) begin errors++; $display("FAIL midrst_pulse: S=%b required 1", bus.S); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.S, bus.R, bus.busy, bus.done, bus.err} !== 5'b00000) begin
      errors++;
      $display("FAIL midrst_clear: S,R,busy,done,err=%b required 00000",
               {bus.S, bus.R, bus.busy, bus.done, bus.err});
    end
    rst = 1'b0;
    anyDoneErr = 1'b0;
    allReady   = 1'b1;
    repeat (8) begin
      @(negedge clk);
      anyDoneErr = anyDoneErr | bus.done | bus.err | bus.S | bus.R;
      allReady   = allReady & bus.req_ready;
    end
    checks++;
    if (anyDoneErr !== 1'b0) begin errors++; $display("FAIL midrst_quiet: activity=%b required 0", anyDoneErr); end
    checks++;
    if (allReady !== 1'b1) begin errors++; $display("FAIL midrst_ready: req_ready=%b required 1", allReady); end
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_set   = 1'b0;
    test_reset();
    test_set();
    test_redundant();
    test_reset_cmd();
    test_retry_err();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
